// File: rtl/moving_avg_filter_if.sv
// Codec FIFO handshake bundle for moving_avg_filter: ready flags, sample buses and pop/push strobes.
// master = filter side, slave = codec FIFO side.
interface moving_avg_filter_if #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned NCH    = 2
);
   logic                  read_ready;
   logic                  write_ready;
   logic [NCH*DATA_W-1:0] readdata;
   logic [NCH*DATA_W-1:0] writedata;
   logic                  read_out;
   logic                  write_out;

   modport master (
      input  read_ready, write_ready, readdata,
      output writedata, read_out, write_out
   );

   modport slave (
      output read_ready, write_ready, readdata,
      input  writedata, read_out, write_out
   );
endinterface

// File: rtl/moving_avg_filter.sv
// Boxcar moving-average filter, NCH independent channels over 2^LOG2_N samples.
// Define MAF_ROUND_EN to round half-up on the output shift instead of flooring.
module moving_avg_filter #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned LOG2_N = 3,
   parameter int unsigned NCH    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   moving_avg_filter_if.master bus,
   output logic                primed
);
   localparam int unsigned N     = 1 << LOG2_N;
   localparam int unsigned ACC_W = DATA_W + LOG2_N;
   localparam int unsigned CNT_W = LOG2_N + 1;
`ifdef MAF_ROUND_EN
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(N / 2);
`endif

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e                  state_q, state_d;
   logic [LOG2_N-1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q [NCH];
   logic signed [ACC_W-1:0] acc_d [NCH];
   logic signed [ACC_W-1:0] acc_next [NCH];
   logic signed [ACC_W-1:0] x_ext [NCH];
   logic signed [ACC_W-1:0] old_ext [NCH];
   logic [NCH*DATA_W-1:0]   wd_q, wd_d;
   logic [DATA_W-1:0]       hist_q [NCH][N];
   logic [DATA_W-1:0]       hist_wdata [NCH];
   logic                    hist_we;
   logic                    accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StClear;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = StClear;
      end else begin
         unique case (state_q)
            StClear: if (ptr_q == LOG2_N'(N - 1)) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StClear;
         endcase
      end
   end

   always_comb begin
      accept        = bus.read_ready & bus.write_ready & (state_q == StRun) & ~clear;
      bus.read_out  = accept;
      bus.write_out = accept;
      bus.writedata = wd_q;
      primed        = (cnt_q == CNT_W'(N));
   end

   // The CLEAR walk reuses ptr to zero one history slot per cycle.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      hist_we = 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
         x_ext[c]      = ACC_W'($signed(bus.readdata[c*DATA_W +: DATA_W]));
         old_ext[c]    = ACC_W'($signed(hist_q[c][ptr_q]));
         acc_next[c]   = acc_q[c] + x_ext[c] - old_ext[c];
         acc_d[c]      = acc_q[c];
         hist_wdata[c] = '0;
      end
      if (clear) begin
         ptr_d = '0;
         cnt_d = '0;
         wd_d  = '0;
         for (int unsigned c = 0; c < NCH; c++) acc_d[c] = '0;
      end else if (state_q == StClear) begin
         ptr_d   = ptr_q + 1'b1;
         hist_we = 1'b1;
      end else if (accept) begin
         ptr_d   = ptr_q + 1'b1;
         hist_we = 1'b1;
         if (cnt_q != CNT_W'(N)) cnt_d = cnt_q + 1'b1;
         for (int unsigned c = 0; c < NCH; c++) begin
            acc_d[c]      = acc_next[c];
            hist_wdata[c] = bus.readdata[c*DATA_W +: DATA_W];
`ifdef MAF_ROUND_EN
            wd_d[c*DATA_W +: DATA_W] = DATA_W'((acc_next[c] + HALF) >>> LOG2_N);
`else
            wd_d[c*DATA_W +: DATA_W] = DATA_W'(acc_next[c] >>> LOG2_N);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
         wd_q  <= '0;
         for (int unsigned c = 0; c < NCH; c++) acc_q[c] <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         wd_q  <= wd_d;
         for (int unsigned c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
      end
   end

   // History is zeroed by the CLEAR walk, so it carries no reset.
   always_ff @(posedge clk) begin
      if (hist_we) begin
         for (int unsigned c = 0; c < NCH; c++) hist_q[c][ptr_q] <= hist_wdata[c];
      end
   end
endmodule

// File: tb/tb_moving_avg_filter.sv
// Bench for moving_avg_filter: vector table, hand sequences and random traffic
// checked against a sliding-window average model.
module tb_moving_avg_filter;
   localparam int DW = 24;
   localparam int N  = 8;

   logic clk = 1'b0;
   logic reset;
   logic clear;
   logic primed;

   moving_avg_filter_if #(.DATA_W(DW), .NCH(2)) bus ();

   moving_avg_filter #(.DATA_W(DW), .LOG2_N(3), .NCH(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .bus    (bus),
      .primed (primed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [23:0] x0;
      logic signed [23:0] x1;
      int                 reps;
      logic signed [23:0] e0;
      logic signed [23:0] e1;
      bit                 pr;
   } vec_t;

   vec_t        tbl[12];
   int          n_tests = 0;
   int          n_fail  = 0;
   longint      win[2][N];
   int          acc_cnt;
   int          clr_wait;
   logic [47:0] exp_wd;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] model_avg(input int ch);
      longint s = 0;
      for (int i = 0; i < N; i++) s += win[ch][i];
`ifdef MAF_ROUND_EN
      s += N / 2;
`endif
      if (s < 0) s = -((-s + N - 1) / N);
      else       s = s / N;
      return s[23:0];
   endfunction

   task automatic model_clear();
      for (int ch = 0; ch < 2; ch++)
         for (int i = 0; i < N; i++) win[ch][i] = 0;
      acc_cnt  = 0;
      exp_wd   = '0;
      clr_wait = N;
   endtask

   task automatic model_accept(input logic signed [23:0] x0, input logic signed [23:0] x1);
      for (int i = N - 1; i > 0; i--) begin
         win[0][i] = win[0][i-1];
         win[1][i] = win[1][i-1];
      end
      win[0][0] = longint'(x0);
      win[1][0] = longint'(x1);
      exp_wd    = {model_avg(1), model_avg(0)};
      if (acc_cnt < N) acc_cnt++;
   endtask

   // One clock: drive, check handshake, take the edge, check registered outputs.
   task automatic cycle(input bit rr, input bit wr, input bit clr,
                        input logic signed [23:0] x0, input logic signed [23:0] x1);
      bit exp_acc;
      bus.read_ready  = rr;
      bus.write_ready = wr;
      clear           = clr;
      bus.readdata    = {x1, x0};
      exp_acc         = rr & wr & ~clr & (clr_wait == 0);
      #1;
      check("read_out", 24'(bus.read_out), 24'(exp_acc));
      check("write_out", 24'(bus.write_out), 24'(exp_acc));
      @(posedge clk);
      if (clr)               model_clear();
      else if (exp_acc)      model_accept(x0, x1);
      else if (clr_wait > 0) clr_wait--;
      #1;
      check("wd_ch0", bus.writedata[23:0], exp_wd[23:0]);
      check("wd_ch1", bus.writedata[47:24], exp_wd[47:24]);
      check("primed", 24'(primed), 24'(acc_cnt == N));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset           = 1'b1;
      clear           = 1'b0;
      bus.read_ready  = 1'b0;
      bus.write_ready = 1'b0;
      bus.readdata    = '0;
      model_clear();

      for (int i = 0; i < 8; i++)
         tbl[i] = '{x0: 24'sd800, x1: 24'sd800, reps: 1,
                    e0: 24'(100 * (i + 1)), e1: 24'(100 * (i + 1)), pr: (i == 7)};
      tbl[8]  = '{x0: 24'sd800, x1: 24'sd800, reps: 2, e0: 24'sd800, e1: 24'sd800, pr: 1'b1};
      // Round-half-up of an all -1 window still lands on -1.
      tbl[9]  = '{x0: -24'sd1, x1: -24'sd1, reps: 8, e0: -24'sd1, e1: -24'sd1, pr: 1'b1};
      tbl[10] = '{x0: 24'h7fffff, x1: 24'h7fffff, reps: 8,
                  e0: 24'h7fffff, e1: 24'h7fffff, pr: 1'b1};
      tbl[11] = '{x0: 24'sd1000, x1: -24'sd1000, reps: 8, e0: 24'sd1000, e1: -24'sd1000, pr: 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_wd0", bus.writedata[23:0], 24'd0);
      check("rst_wd1", bus.writedata[47:24], 24'd0);
      check("rst_read_out", 24'(bus.read_out), 24'd0);
      check("rst_write_out", 24'(bus.write_out), 24'd0);
      check("rst_primed", 24'(primed), 24'd0);
      reset = 1'b0;

      // CLEAR walk after reset: eight idle cycles, then accept opens.
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 24'sd0, 24'sd0);
      bus.readdata = {24'd800, 24'd800};
      #1;
      check("first_accept", 24'(bus.read_out), 24'd1);

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) cycle(1'b1, 1'b1, 1'b0, tbl[i].x0, tbl[i].x1);
         check($sformatf("tbl%0d_ch0", i), bus.writedata[23:0], tbl[i].e0);
         check($sformatf("tbl%0d_ch1", i), bus.writedata[47:24], tbl[i].e1);
         check($sformatf("tbl%0d_primed", i), 24'(primed), 24'(tbl[i].pr));
      end

      // Flush at steady 800, ramp restart, stall mid-ramp.
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 24'sd800, 24'sd800);
      cycle(1'b1, 1'b1, 1'b1, 24'sd800, 24'sd800);
      check("clr_wd", bus.writedata[23:0], 24'd0);
      check("clr_primed", 24'(primed), 24'd0);
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 24'sd800, 24'sd800);
      for (int k = 1; k <= 3; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 24'sd800, 24'sd800);
         check($sformatf("ramp%0d", k), bus.writedata[23:0], 24'(100 * k));
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 24'sd800, 24'sd800);
      check("stall_hold", bus.writedata[23:0], 24'd300);
      check("stall_primed", 24'(primed), 24'd0);
      cycle(1'b1, 1'b1, 1'b0, 24'sd800, 24'sd800);
      check("resume", bus.writedata[23:0], 24'd400);

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
               24'($urandom), 24'($urandom));

      // Asynchronous reset between edges.
      for (int i = 0; i < 2 * N; i++) cycle(1'b1, 1'b1, 1'b0, 24'sd5000, -24'sd3000);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_wd0", bus.writedata[23:0], 24'd0);
      check("arst_wd1", bus.writedata[47:24], 24'd0);
      check("arst_read_out", 24'(bus.read_out), 24'd0);
      check("arst_primed", 24'(primed), 24'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 24'sd800, 24'sd800);
      cycle(1'b1, 1'b1, 1'b0, 24'sd800, 24'sd800);
      check("arst_ramp", bus.writedata[23:0], 24'd100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
